// File: rtl/versa_reset_ctrl.sv
// -----------------------------------------------------------------------------
// versa_reset_ctrl
//
// Reset sequencer for the MSP430 core, driven by the VERSA violation monitors.
// Any violation raises the core reset in the same cycle. The reset is then
// stretched to a minimum length. After release, the controller waits for the
// core to fetch from RESET_HANDLER; if the core does not get there in time, the
// sequence restarts. A sticky cause vector and a saturating trigger counter
// remain readable after recovery for diagnosis.
//
// Ports
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset (power-on)
//   viol       in   per-monitor violation levels, bit 0 atomicity, 1 irq_dma,
//                   2 rp_gpio, 3 rp_ekey, 4 wp_ekey, 5 wp_ctr
//   pc         in   current program counter of the core
//   cause_clr  in   one-cycle pulse that clears cause (only acted on in IDLE)
//   reset      out  core reset request, active high
//   cause      out  sticky OR of violation bits seen since the last clear
//   viol_cnt   out  saturating count of reset triggers
//   busy       out  high while a reset sequence is in progress
// -----------------------------------------------------------------------------
module versa_reset_ctrl #(
  parameter int          NUM_SRC       = 6,
  parameter int          HOLD_CYCLES   = 4,
  parameter int          WAIT_MAX      = 16,
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter int          CNT_W         = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] viol,
  input  logic [15:0]        pc,
  input  logic               cause_clr,
  output logic               reset,
  output logic [NUM_SRC-1:0] cause,
  output logic [CNT_W-1:0]   viol_cnt,
  output logic               busy
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_MAX - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    WAIT_PC = 2'd2
  } state_t;

  state_t             state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               any_viol;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] all_ones;
    all_ones = {CNT_W{1'b1}};
    if (v == all_ones) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  assign any_viol = |viol;

  // Reset follows the violation inputs with no register in the path, so a
  // monitor firing stops the core in the same cycle. The reset is also held
  // asserted in any state other than IDLE and WAIT_PC, which includes the
  // unused state encoding.
  assign reset = ((state != IDLE) && (state != WAIT_PC)) || any_viol;
  assign busy  = (state != IDLE);

  // Sequencer state, stretch and watchdog counters, and diagnostic registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // Power-on enters HOLD so that the stretch also applies after reset_n.
      // This entry is not a violation and is not counted.
      state    <= HOLD;
      hold_cnt <= HOLD_LOAD;
      wait_cnt <= {WAIT_W{1'b0}};
      cause    <= {NUM_SRC{1'b0}};
      viol_cnt <= {CNT_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (any_viol) begin
            // A trigger beats a simultaneous clear: the old cause is dropped
            // and only the new sources are kept.
            state    <= HOLD;
            hold_cnt <= HOLD_LOAD;
            cause    <= cause_clr ? viol : (cause | viol);
            viol_cnt <= sat_inc(viol_cnt);
          end else if (cause_clr) begin
            cause <= {NUM_SRC{1'b0}};
          end
        end

        HOLD: begin
          cause <= cause | viol;
          if (hold_cnt == {HOLD_W{1'b0}}) begin
            if (any_viol) begin
              // A persisting violation keeps reset asserted. It is the
              // same event, so it is not counted again.
              hold_cnt <= HOLD_LOAD;
            end else begin
              state    <= WAIT_PC;
              wait_cnt <= WAIT_LOAD;
            end
          end else begin
            hold_cnt <= hold_cnt - HOLD_ONE;
          end
        end

        WAIT_PC: begin
          if (any_viol) begin
            state    <= HOLD;
            hold_cnt <= HOLD_LOAD;
            cause    <= cause | viol;
            viol_cnt <= sat_inc(viol_cnt);
          end else if (pc == RESET_HANDLER) begin
            state <= IDLE;
          end else if (wait_cnt == {WAIT_W{1'b0}}) begin
            // The core failed to re-enter the handler. This restarts the
            // reset and is counted, but no source bit belongs to it.
            state    <= HOLD;
            hold_cnt <= HOLD_LOAD;
            viol_cnt <= sat_inc(viol_cnt);
          end else begin
            wait_cnt <= wait_cnt - WAIT_ONE;
          end
        end

        default: begin
          // Unused encoding: fall back to a fresh reset sequence.
          state    <= HOLD;
          hold_cnt <= HOLD_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_versa_reset_ctrl.sv
// -----------------------------------------------------------------------------
// tb_versa_reset_ctrl
//
// Self-checking bench for versa_reset_ctrl. Instance "dut" uses the default
// parameters. Instance "dut_s" has CNT_W=2 and receives the same stimulus, so
// its counter must saturate at 3 while every other output tracks dut.
// Each cycle is described by one record holding the inputs and the outputs
// expected in that cycle. Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_versa_reset_ctrl;

  logic        clk;
  logic        reset_n;
  logic [5:0]  viol;
  logic [15:0] pc;
  logic        cause_clr;

  logic        reset_a, busy_a;
  logic [5:0]  cause_a;
  logic [7:0]  cnt_a;
  logic        reset_b, busy_b;
  logic [5:0]  cause_b;
  logic [1:0]  cnt_b;

  versa_reset_ctrl dut (
    .clk(clk), .reset_n(reset_n), .viol(viol), .pc(pc), .cause_clr(cause_clr),
    .reset(reset_a), .cause(cause_a), .viol_cnt(cnt_a), .busy(busy_a)
  );

  versa_reset_ctrl #(.CNT_W(2)) dut_s (
    .clk(clk), .reset_n(reset_n), .viol(viol), .pc(pc), .cause_clr(cause_clr),
    .reset(reset_b), .cause(cause_b), .viol_cnt(cnt_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  viol;
    logic [15:0] pc;
    logic        clr;
    logic        exp_reset;
    logic        exp_busy;
    logic [5:0]  exp_cause;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   step_no = 0;

  function automatic vec_t mk(input logic [5:0] v, input logic [15:0] p,
                              input logic c, input logic r, input logic b,
                              input logic [5:0] ca, input logic [7:0] n);
    vec_t t;
    t.viol = v; t.pc = p; t.clr = c;
    t.exp_reset = r; t.exp_busy = b; t.exp_cause = ca; t.exp_cnt = n;
    return t;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic r, input logic b,
                           input logic [5:0] ca, input logic [7:0] n);
    logic [7:0] n_sat;
    n_sat = (n > 8'd3) ? 8'd3 : n;
    chk("reset",   idx, {31'd0, reset_a}, {31'd0, r});
    chk("busy",    idx, {31'd0, busy_a},  {31'd0, b});
    chk("cause",   idx, {26'd0, cause_a}, {26'd0, ca});
    chk("cnt",     idx, {24'd0, cnt_a},   {24'd0, n});
    chk("reset_s", idx, {31'd0, reset_b}, {31'd0, r});
    chk("busy_s",  idx, {31'd0, busy_b},  {31'd0, b});
    chk("cause_s", idx, {26'd0, cause_b}, {26'd0, ca});
    chk("cnt_sat", idx, {30'd0, cnt_b},   {24'd0, n_sat});
  endtask

  // One clock cycle. The expectation is queued when the inputs are driven and
  // retired when the outputs are sampled mid-cycle.
  task automatic step(input vec_t v);
    vec_t e;
    viol = v.viol; pc = v.pc; cause_clr = v.clr;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    check_all(step_no, e.exp_reset, e.exp_busy, e.exp_cause, e.exp_cnt);
    step_no++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    viol = 6'd0; pc = 16'd0; cause_clr = 1'b0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check_all(-1, 1'b1, 1'b1, 6'h00, 8'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    // Power-on: 4 stretched cycles, then WAIT_PC sees pc==0.
    for (int i = 0; i < 4; i++) tbl.push_back(mk(6'h00, 16'h0000, 1'b0, 1'b1, 1'b1, 6'h00, 8'd0));
    tbl.push_back(mk(6'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 6'h00, 8'd0));
    tbl.push_back(mk(6'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 6'h00, 8'd0));
    // Single-cycle rp_gpio pulse: reset in the pulse cycle plus 4 HOLD cycles.
    tbl.push_back(mk(6'b000100, 16'h1234, 1'b0, 1'b1, 1'b0, 6'h00, 8'd0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(6'h00, 16'h1234, 1'b0, 1'b1, 1'b1, 6'h04, 8'd1));
    tbl.push_back(mk(6'h00, 16'h1234, 1'b0, 1'b0, 1'b1, 6'h04, 8'd1));
    tbl.push_back(mk(6'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 6'h04, 8'd1));
    tbl.push_back(mk(6'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 6'h04, 8'd1));
    // Clear alone, then build cause = 6'b100001.
    tbl.push_back(mk(6'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 6'h04, 8'd1));
    tbl.push_back(mk(6'b100001, 16'h1234, 1'b0, 1'b1, 1'b0, 6'h00, 8'd1));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(6'h00, 16'h1234, 1'b0, 1'b1, 1'b1, 6'h21, 8'd2));
    tbl.push_back(mk(6'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 6'h21, 8'd2));
    // Clear alone in IDLE, then clear together with a trigger.
    tbl.push_back(mk(6'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 6'h21, 8'd2));
    tbl.push_back(mk(6'b000010, 16'h1234, 1'b1, 1'b1, 1'b0, 6'h00, 8'd2));
    // A clear in HOLD is ignored: cause stays 6'b000010.
    tbl.push_back(mk(6'h00, 16'h1234, 1'b1, 1'b1, 1'b1, 6'h02, 8'd3));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(6'h00, 16'h1234, 1'b0, 1'b1, 1'b1, 6'h02, 8'd3));
    tbl.push_back(mk(6'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 6'h02, 8'd3));
    tbl.push_back(mk(6'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 6'h02, 8'd3));

    foreach (tbl[i]) step(tbl[i]);

    // Held atomicity violation for 10 cycles. There is a single count. The
    // reload after cycles 4 and 8 leaves hold_cnt at 2 when viol drops, so
    // reset stays high for 3 more cycles.
    for (int i = 0; i < 10; i++)
      step(mk(6'b000001, 16'h4400, 1'b0, 1'b1, (i == 0) ? 1'b0 : 1'b1,
              (i == 0) ? 6'h02 : 6'h03, (i == 0) ? 8'd3 : 8'd4));
    for (int i = 0; i < 3; i++) step(mk(6'h00, 16'h4400, 1'b0, 1'b1, 1'b1, 6'h03, 8'd4));
    step(mk(6'h00, 16'h4400, 1'b0, 1'b0, 1'b1, 6'h03, 8'd4));

    // Re-violation in WAIT_PC with pc=16'h4400: wp_ekey joins the cause.
    step(mk(6'b010000, 16'h4400, 1'b0, 1'b1, 1'b1, 6'h03, 8'd4));
    for (int i = 0; i < 4; i++) step(mk(6'h00, 16'h4400, 1'b0, 1'b1, 1'b1, 6'h13, 8'd5));

    // Watchdog: 16 WAIT_PC cycles without reaching the handler, then HOLD.
    for (int i = 0; i < 16; i++) step(mk(6'h00, 16'h4400, 1'b0, 1'b0, 1'b1, 6'h13, 8'd5));
    step(mk(6'h00, 16'h4400, 1'b0, 1'b1, 1'b1, 6'h13, 8'd6));

    // reset_n asserted mid-HOLD, away from a clock edge, clears at once.
    #2 reset_n = 1'b0;
    #1;
    check_all(1000, 1'b1, 1'b1, 6'h00, 8'd0);
    @(posedge clk); #1;
    check_all(1001, 1'b1, 1'b1, 6'h00, 8'd0);
    reset_n = 1'b1;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
